// File: rtl/bus_terminal_fifo_if.sv
// bus_terminal_fifo_if
//   Bundles the bus-side handshake (pndng/pop/D_pop, push/D_push) and the
//   host-side queue access, status and error signals of one bus terminal.
//   slave  : terminal side (bus_terminal_fifo)
//   master : bus driver / host side (testbench or surrounding logic)
interface bus_terminal_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int cnt_w   = 8
);
    localparam int occ_w = $clog2(depth + 1);

    // bus side
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    // host side
    logic               wr_en;
    logic [pckg_sz-1:0] wr_data;
    logic               tx_full;
    logic               rd_en;
    logic [pckg_sz-1:0] rd_data;
    logic               rx_pndng;
    // status
    logic [occ_w-1:0]   tx_count;
    logic [occ_w-1:0]   rx_count;
    logic [cnt_w-1:0]   tx_drop;
    logic [cnt_w-1:0]   rx_drop;
    logic               udf;

    modport slave (
        input  pop, push, D_push, wr_en, wr_data, rd_en,
        output pndng, D_pop, tx_full, rd_data, rx_pndng,
               tx_count, rx_count, tx_drop, rx_drop, udf
    );

    modport master (
        output pop, push, D_push, wr_en, wr_data, rd_en,
        input  pndng, D_pop, tx_full, rd_data, rx_pndng,
               tx_count, rx_count, tx_drop, rx_drop, udf
    );
endinterface

// File: rtl/bus_terminal_fifo.sv
// bus_terminal_fifo
//   Terminal-side responder for the bus driver. Holds a TX queue emptied by
//   the bus (pndng/pop/D_pop) and filled by the host (wr_en/wr_data), and an
//   RX queue filled by the bus (push/D_push) and drained by the host
//   (rd_en/rd_data). Reports occupancy, saturating drop counts and a sticky
//   underflow flag.
//   Ports:
//     clk   : single clock, rising edge
//     reset : asynchronous, active-low
//     bus   : bus_terminal_fifo_if.slave (all handshake, data and status)

// One circular-buffer queue. Both TX and RX are instances of this.
//   wr/wdata : enqueue request;  rd : dequeue request
//   head     : show-ahead head entry, 0 when empty
//   count    : occupancy;  drop : saturating dropped-write count
//   udf      : sticky, set by rd while empty
module bus_terminal_fifo_queue #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [W-1:0]     wdata,
    input  logic             rd,
    output logic [W-1:0]     head,
    output logic [OCC_W-1:0] count,
    output logic [CNT_W-1:0] drop,
    output logic             udf
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             empty, full;
    logic             do_rd, do_wr, drop_evt, udf_evt;

    assign empty = (count == '0);
    assign full  = (count == OCC_W'(DEPTH));

    // A read on a non-empty queue frees a slot on the same edge, so a write
    // at full is still accepted when it coincides with a legal read.
    assign do_rd    = rd & ~empty;
    assign do_wr    = wr & (~full | do_rd);
    assign drop_evt = wr & ~do_wr;
    assign udf_evt  = rd & empty;

    // Payload storage needs no reset; head is masked by count.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            drop   <= '0;
            udf    <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (do_rd)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            if (drop_evt && (drop != '1))
                drop <= drop + CNT_W'(1);
            if (udf_evt)
                udf <= 1'b1;
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];
endmodule

module bus_terminal_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int cnt_w   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    bus_terminal_fifo_if.slave     bus
);
    localparam int OCC_W  = $clog2(depth + 1);
    localparam int NUM_Q  = 2;
    localparam int TX     = 0;
    localparam int RX     = 1;

    logic [NUM_Q-1:0]              q_wr, q_rd, q_udf;
    logic [NUM_Q-1:0][pckg_sz-1:0] q_wdata, q_head;
    logic [NUM_Q-1:0][OCC_W-1:0]   q_count;
    logic [NUM_Q-1:0][cnt_w-1:0]   q_drop;

    // TX: host writes, bus pops.  RX: bus pushes, host reads.
    assign q_wr[TX]    = bus.wr_en;
    assign q_wdata[TX] = bus.wr_data;
    assign q_rd[TX]    = bus.pop;
    assign q_wr[RX]    = bus.push;
    assign q_wdata[RX] = bus.D_push;  // stored verbatim, dest-ID bits included
    assign q_rd[RX]    = bus.rd_en;

    for (genvar q = 0; q < NUM_Q; q++) begin : g_q
        bus_terminal_fifo_queue #(
            .W     (pckg_sz),
            .DEPTH (depth),
            .CNT_W (cnt_w),
            .OCC_W (OCC_W)
        ) u_queue (
            .clk   (clk),
            .reset (reset),
            .wr    (q_wr[q]),
            .wdata (q_wdata[q]),
            .rd    (q_rd[q]),
            .head  (q_head[q]),
            .count (q_count[q]),
            .drop  (q_drop[q]),
            .udf   (q_udf[q])
        );
    end

    // All status is a function of queue registers only.
    assign bus.pndng    = (q_count[TX] != '0);
    assign bus.D_pop    = q_head[TX];
    assign bus.tx_full  = (q_count[TX] == OCC_W'(depth));
    assign bus.tx_count = q_count[TX];
    assign bus.tx_drop  = q_drop[TX];
    assign bus.rx_pndng = (q_count[RX] != '0);
    assign bus.rd_data  = q_head[RX];
    assign bus.rx_count = q_count[RX];
    assign bus.rx_drop  = q_drop[RX];
    assign bus.udf      = |q_udf;
endmodule
